mem_channel_model: RTL and testbench
====================================

Name: mem_channel_model

Overview:
- Parametrised, synthesizable multi-channel memory responder that replaces the behavioural memory helper class in GPU benches.
- Serves program or data memory over the mem_if valid/ready handshake, with CHANNELS independent request channels.
- Adds features the class lacks: configurable access latency, optional single-port round-robin arbitration, out-of-range handling, and a preload/debug port.
- Sits between the gpu memory controllers and the bench; one instance is used for program memory and one for data memory.

Parameters:
- ADDR_BITS, 8, address width.
- DATA_BITS, 8, word width (16 for program memory).
- CHANNELS, 4, number of request channels.
- DEPTH, 2**ADDR_BITS, number of implemented words; DEPTH <= 2**ADDR_BITS.
- LATENCY, 2, cycles from request capture to ready; minimum 1.
- SINGLE_PORT, 0; when 1, at most one storage access per cycle, granted round-robin.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- mem_read_valid  in  CHANNELS  per-channel read request.
- mem_read_address  in  CHANNELS x ADDR_BITS  per-channel read address.
- mem_read_ready  out  CHANNELS  per-channel read response valid.
- mem_read_data  out  CHANNELS x DATA_BITS  per-channel read data.
- mem_write_valid  in  CHANNELS  per-channel write request.
- mem_write_address  in  CHANNELS x ADDR_BITS  per-channel write address.
- mem_write_data  in  CHANNELS x DATA_BITS  per-channel write data.
- mem_write_ready  out  CHANNELS  per-channel write acknowledge.
- load_en  in  1  preload write strobe.
- load_addr  in  ADDR_BITS  preload address.
- load_data  in  DATA_BITS  preload data.
- dbg_addr  in  ADDR_BITS  debug read address.
- dbg_data  out  DATA_BITS  combinational debug read of storage; 0 if dbg_addr >= DEPTH.

Behaviour:
- Reset (asynchronous): all ready outputs 0, all read_data 0, every channel FSM in IDLE, latency counters 0, round-robin pointer 0. Storage is not cleared.
- Per-channel FSM states IDLE, WAIT, RESPOND.
- IDLE: on read_valid, capture address and op=READ. Otherwise on write_valid, capture address, data and op=WRITE. Read wins if both are asserted. Load cnt=LATENCY-1 and go to WAIT.
- WAIT: if cnt != 0, decrement. If cnt == 0 and the channel is granted, perform the access and go to RESPOND. Ungranted channels hold in WAIT with cnt=0.
- Grant: with SINGLE_PORT=0, every channel is always granted. With SINGLE_PORT=1, grant the first WAIT/cnt==0 channel at or after the pointer; the pointer moves to granted+1 mod CHANNELS.
- load_en blocks all grants that cycle in SINGLE_PORT=1 mode.
- Latency: valid sampled at edge k with no contention gives ready high after edge k+LATENCY.
- RESPOND: assert the matching ready (read_data held stable). Stay in RESPOND while the matching valid is high. When it is low, deassert ready and go to IDLE. No new capture in the same cycle as leaving RESPOND.
- A request whose valid drops during WAIT still completes. The write commits, and ready pulses for exactly one cycle.
- Out-of-range address (>= DEPTH): read returns 0, write is dropped, handshake completes normally.
- Same-cycle storage conflicts:
  - load beats channel writes.
  - Among channel writes to the same address, the lowest channel index wins.
  - A read and a write to the same address in the same cycle: the read returns old data.
- Reset mid-operation aborts all pending requests; uncommitted writes are lost.

Decomposition:
- mem_model_pkg: chan_state_e {IDLE, WAIT, RESPOND}, mem_op_e {OP_READ, OP_WRITE}, latency counter width function clog2(LATENCY+1).
- Sub-module mem_chan_fsm (one per channel, via generate): capture registers, counter, ready/data outputs, req/grant interface.
- Top level holds storage, the arbiter and write-priority resolution.

Test Plan:
- Preload words 0..7 at addr 0..7; ch0 reads addr 5 with LATENCY=2 -> read_ready rises 2 cycles after capture with data 5, and falls 1 cycle after valid drops.
- SINGLE_PORT=1, all 4 channels read addr 0..3 at the same edge -> ready rises on ch0, ch1, ch2, ch3 in consecutive cycles. Next simultaneous burst starts at ch0 (pointer wrapped to 0).
- SINGLE_PORT=0: ch1 and ch2 write 0xAA and 0x55 to addr 16 at the same edge -> dbg_data(16)=0xAA. Concurrent ch0 read of addr 16 returns the old value.
- DEPTH=16: write 0x7 to addr 20, then read addr 20 -> write_ready handshake completes, read returns 0, storage unchanged.
- ch0 read_valid drops after 1 cycle in WAIT (LATENCY=3) -> read_ready high for exactly 1 cycle, then IDLE. Next request accepted normally.
- Assert reset while ch0 is in WAIT with a write of 0x33 to addr 9 -> all ready outputs 0 immediately and addr 9 unchanged. After release, a new read of addr 9 returns the preloaded value.

Source files
------------

// File: rtl/mem_model_pkg.sv
// rtl/mem_model_pkg.sv - shared types and helpers for the multi-channel memory responder
// Purpose: channel FSM state and operation enums plus the latency counter width helper.
// Ports: none (package).
package mem_model_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } chan_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_e;

  // Counter must hold LATENCY-1; sized as clog2(LATENCY+1) so LATENCY=1 still gets one bit.
  function automatic int cnt_width(input int latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/mem_chan_fsm.sv
// rtl/mem_chan_fsm.sv - per-channel request capture, latency countdown and response handshake
// Purpose: captures one read or write request, counts down the access latency, raises a
//          storage request and, once granted, completes the handshake on the ready outputs.
// Ports:
//   i_clk, i_rst                   clock, asynchronous active-high reset
//   i_read_valid/i_read_address    channel read request
//   i_write_valid/i_write_address/i_write_data  channel write request
//   i_grant                        storage access granted this cycle
//   i_rd_data                      storage word at o_addr (0 when out of range)
//   o_req                          waiting with expired counter, wants storage access
//   o_op/o_addr/o_wdata            captured operation for the storage side
//   o_read_ready/o_write_ready     registered response strobes
//   o_read_data                    registered read data, held while responding
module mem_chan_fsm
  import mem_model_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_read_valid,
  input  logic [ADDR_BITS-1:0] i_read_address,
  input  logic                 i_write_valid,
  input  logic [ADDR_BITS-1:0] i_write_address,
  input  logic [DATA_BITS-1:0] i_write_data,
  input  logic                 i_grant,
  input  logic [DATA_BITS-1:0] i_rd_data,
  output logic                 o_req,
  output mem_op_e              o_op,
  output logic [ADDR_BITS-1:0] o_addr,
  output logic [DATA_BITS-1:0] o_wdata,
  output logic                 o_read_ready,
  output logic                 o_write_ready,
  output logic [DATA_BITS-1:0] o_read_data
);

  localparam int CW = cnt_width(LATENCY);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  chan_state_e          r_state;
  mem_op_e              r_op;
  logic [ADDR_BITS-1:0] r_addr;
  logic [DATA_BITS-1:0] r_wdata;
  logic [DATA_BITS-1:0] r_rdata;
  logic [CW-1:0]        r_cnt;
  logic                 r_rready;
  logic                 r_wready;
  logic                 w_valid_match;

  // The request stays alive only while the valid of the captured operation is held.
  assign w_valid_match = (r_op == OP_READ) ? i_read_valid : i_write_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_op     <= OP_READ;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_cnt    <= '0;
      r_rready <= 1'b0;
      r_wready <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_read_valid) begin
            r_op    <= OP_READ;
            r_addr  <= i_read_address;
            r_cnt   <= CNT_LOAD;
            r_state <= WAIT;
          end else if (i_write_valid) begin
            r_op    <= OP_WRITE;
            r_addr  <= i_write_address;
            r_wdata <= i_write_data;
            r_cnt   <= CNT_LOAD;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (i_grant) begin
            // Storage commits the write on this same edge; only the ack is ours.
            if (r_op == OP_READ) begin
              r_rdata  <= i_rd_data;
              r_rready <= 1'b1;
            end else begin
              r_wready <= 1'b1;
            end
            r_state <= RESPOND;
          end
        end
        RESPOND: begin
          if (!w_valid_match) begin
            r_rready <= 1'b0;
            r_wready <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req         = (r_state == WAIT) && (r_cnt == '0);
  assign o_op          = r_op;
  assign o_addr        = r_addr;
  assign o_wdata       = r_wdata;
  assign o_read_ready  = r_rready;
  assign o_write_ready = r_wready;
  assign o_read_data   = r_rdata;

endmodule

// File: rtl/mem_channel_model.sv
// rtl/mem_channel_model.sv - multi-channel memory responder with latency, arbitration and preload
// Purpose: storage array shared by CHANNELS request channels, optional single-port round-robin
//          arbitration, write priority resolution, preload and combinational debug read.
// Ports:
//   clk, reset                                   clock, asynchronous active-high reset
//   mem_read_valid/address, mem_read_ready/data  per-channel read handshake
//   mem_write_valid/address/data, mem_write_ready per-channel write handshake
//   load_en/load_addr/load_data                  preload write port (beats channel writes)
//   dbg_addr/dbg_data                            combinational debug read, 0 when out of range
module mem_channel_model
  import mem_model_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int DATA_BITS   = 8,
  parameter int CHANNELS    = 4,
  parameter int DEPTH       = 2**ADDR_BITS,
  parameter int LATENCY     = 2,
  parameter int SINGLE_PORT = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [CHANNELS-1:0]                 mem_read_valid,
  input  logic [CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
  output logic [CHANNELS-1:0]                 mem_read_ready,
  output logic [CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
  input  logic [CHANNELS-1:0]                 mem_write_valid,
  input  logic [CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
  input  logic [CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
  output logic [CHANNELS-1:0]                 mem_write_ready,
  input  logic                                load_en,
  input  logic [ADDR_BITS-1:0]                load_addr,
  input  logic [DATA_BITS-1:0]                load_data,
  input  logic [ADDR_BITS-1:0]                dbg_addr,
  output logic [DATA_BITS-1:0]                dbg_data
);

  localparam int IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [PTR_BITS-1:0]  r_ptr;

  logic [CHANNELS-1:0]  w_req;
  logic [CHANNELS-1:0]  w_grant;
  mem_op_e              w_op      [CHANNELS];
  logic [ADDR_BITS-1:0] w_addr    [CHANNELS];
  logic [DATA_BITS-1:0] w_wdata   [CHANNELS];
  logic [DATA_BITS-1:0] w_rd_data [CHANNELS];
  logic [PTR_BITS-1:0]  w_cand    [CHANNELS];
  logic                 w_any;
  logic [PTR_BITS-1:0]  w_gnt_idx;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    // Round-robin search order, starting at the pointer.
    assign w_cand[g]    = PTR_BITS'((int'(r_ptr) + g) % CHANNELS);
    assign w_rd_data[g] = (int'(w_addr[g]) < DEPTH) ? r_mem[w_addr[g][IDX_BITS-1:0]] : '0;

    mem_chan_fsm #(
      .ADDR_BITS (ADDR_BITS),
      .DATA_BITS (DATA_BITS),
      .LATENCY   (LATENCY)
    ) u_fsm (
      .i_clk           (clk),
      .i_rst           (reset),
      .i_read_valid    (mem_read_valid[g]),
      .i_read_address  (mem_read_address[g]),
      .i_write_valid   (mem_write_valid[g]),
      .i_write_address (mem_write_address[g]),
      .i_write_data    (mem_write_data[g]),
      .i_grant         (w_grant[g]),
      .i_rd_data       (w_rd_data[g]),
      .o_req           (w_req[g]),
      .o_op            (w_op[g]),
      .o_addr          (w_addr[g]),
      .o_wdata         (w_wdata[g]),
      .o_read_ready    (mem_read_ready[g]),
      .o_write_ready   (mem_write_ready[g]),
      .o_read_data     (mem_read_data[g])
    );
  end

  always_comb begin
    w_grant   = '0;
    w_any     = 1'b0;
    w_gnt_idx = '0;
    if (SINGLE_PORT == 0) begin
      w_grant = '1;
    end else if (!load_en) begin
      // A preload occupies the single port, so nobody is granted that cycle.
      for (int k = 0; k < CHANNELS; k++) begin
        if (!w_any && w_req[w_cand[k]]) begin
          w_any              = 1'b1;
          w_gnt_idx          = w_cand[k];
          w_grant[w_cand[k]] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= PTR_BITS'((int'(w_gnt_idx) + 1) % CHANNELS);
    end
  end

  // Storage survives reset. Later assignments win: channels are walked from the highest
  // index down so the lowest index lands last, and the preload overrides all of them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (w_req[i] && w_grant[i] && (w_op[i] == OP_WRITE) && (int'(w_addr[i]) < DEPTH)) begin
          r_mem[w_addr[i][IDX_BITS-1:0]] <= w_wdata[i];
        end
      end
      if (load_en && (int'(load_addr) < DEPTH)) begin
        r_mem[load_addr[IDX_BITS-1:0]] <= load_data;
      end
    end
  end

  assign dbg_data = (int'(dbg_addr) < DEPTH) ? r_mem[dbg_addr[IDX_BITS-1:0]] : '0;

endmodule

// File: tb/tb_mem_channel_model.sv
// tb/tb_mem_channel_model.sv - self-checking bench for mem_channel_model
module tb_mem_channel_model;

  logic clk;
  logic reset;

  // Index 0: DEPTH=256, LATENCY=2, SINGLE_PORT=0.  Index 1: DEPTH=16, LATENCY=3, SINGLE_PORT=1.
  logic [3:0]      rv [2];
  logic [3:0]      wv [2];
  logic [3:0]      rr [2];
  logic [3:0]      wr [2];
  logic [3:0][7:0] ra [2];
  logic [3:0][7:0] wa [2];
  logic [3:0][7:0] wd [2];
  logic [3:0][7:0] rd [2];
  logic            len  [2];
  logic [7:0]      ladr [2];
  logic [7:0]      ldat [2];
  logic [7:0]      dadr [2];
  logic [7:0]      ddat [2];

  logic [7:0] mdl [2][256];
  int n_checks = 0;
  int n_err    = 0;

  mem_channel_model #(.ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(4), .DEPTH(256),
                      .LATENCY(2), .SINGLE_PORT(0)) u_a (
    .clk(clk), .reset(reset),
    .mem_read_valid(rv[0]), .mem_read_address(ra[0]), .mem_read_ready(rr[0]), .mem_read_data(rd[0]),
    .mem_write_valid(wv[0]), .mem_write_address(wa[0]), .mem_write_data(wd[0]), .mem_write_ready(wr[0]),
    .load_en(len[0]), .load_addr(ladr[0]), .load_data(ldat[0]), .dbg_addr(dadr[0]), .dbg_data(ddat[0])
  );

  mem_channel_model #(.ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(4), .DEPTH(16),
                      .LATENCY(3), .SINGLE_PORT(1)) u_b (
    .clk(clk), .reset(reset),
    .mem_read_valid(rv[1]), .mem_read_address(ra[1]), .mem_read_ready(rr[1]), .mem_read_data(rd[1]),
    .mem_write_valid(wv[1]), .mem_write_address(wa[1]), .mem_write_data(wd[1]), .mem_write_ready(wr[1]),
    .load_en(len[1]), .load_addr(ladr[1]), .load_data(ldat[1]), .dbg_addr(dadr[1]), .dbg_data(ddat[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dep(input int s);
    return (s == 0) ? 256 : 16;
  endfunction

  function automatic int lat_of(input int s);
    return (s == 0) ? 2 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int s, input int addr, input logic [7:0] data);
    len[s] = 1'b1; ladr[s] = 8'(addr); ldat[s] = data;
    @(negedge clk);
    len[s] = 1'b0;
    if (addr < dep(s)) mdl[s][addr] = data;
  endtask

  // Holds valid until ready (bounded), drops it, then expects ready to fall one cycle later.
  task automatic xfer(input int s, input int ch, input bit wr_op, input logic [7:0] addr,
                      input logic [7:0] data, output int lat, output logic [7:0] rdat);
    if (wr_op) begin
      wv[s][ch] = 1'b1; wa[s][ch] = addr; wd[s][ch] = data;
    end else begin
      rv[s][ch] = 1'b1; ra[s][ch] = addr;
    end
    lat = -1;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if ((wr_op ? wr[s][ch] : rr[s][ch]) === 1'b1) begin
        lat = t;
        break;
      end
    end
    rdat = rd[s][ch];
    rv[s][ch] = 1'b0; wv[s][ch] = 1'b0;
    @(negedge clk);
    chk("ready_fall", {31'd0, wr_op ? wr[s][ch] : rr[s][ch]}, 32'd0);
  endtask

  task automatic do_read(input int s, input int ch, input int addr);
    int lat;
    logic [7:0] d;
    logic [7:0] exp;
    exp = (addr < dep(s)) ? mdl[s][addr] : 8'h00;
    xfer(s, ch, 1'b0, 8'(addr), 8'h00, lat, d);
    chk("read_latency", lat, lat_of(s) + 1);
    chk("read_data", {24'd0, d}, {24'd0, exp});
  endtask

  task automatic do_write(input int s, input int ch, input int addr, input logic [7:0] data);
    int lat;
    logic [7:0] d;
    xfer(s, ch, 1'b1, 8'(addr), data, lat, d);
    chk("write_latency", lat, lat_of(s) + 1);
    if (addr < dep(s)) mdl[s][addr] = data;
  endtask

  task automatic dbg(input int s, input int addr);
    logic [7:0] exp;
    exp = (addr < dep(s)) ? mdl[s][addr] : 8'h00;
    dadr[s] = 8'(addr);
    #1;
    chk("dbg_data", {24'd0, ddat[s]}, {24'd0, exp});
  endtask

  initial begin
    int ch;
    int op;
    int addr;
    logic [7:0] old;
    logic [3:0] exp_v;

    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      rv[s] = '0; wv[s] = '0; ra[s] = '0; wa[s] = '0; wd[s] = '0;
      len[s] = 1'b0; ladr[s] = '0; ldat[s] = '0; dadr[s] = '0;
    end
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("reset_read_ready", {28'd0, rr[s]}, 32'd0);
      chk("reset_write_ready", {28'd0, wr[s]}, 32'd0);
      chk("reset_read_data", rd[s], 32'd0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Preload: words 0..7 hold their own address, addr 9 a known marker, the rest random.
    for (int a = 0; a < 256; a++)
      load(0, a, (a < 8) ? 8'(a) : (a == 9) ? 8'hC9 : 8'($urandom));
    for (int a = 0; a < 16; a++)
      load(1, a, 8'($urandom));
    dbg(0, 5);
    dbg(1, 15);

    // Basic read with LATENCY=2.
    do_read(0, 0, 5);

    // Randomized single-channel traffic on the multi-port instance.
    for (int i = 0; i < 24; i++) begin
      ch   = $urandom_range(0, 3);
      op   = $urandom_range(0, 1);
      addr = $urandom_range(0, 255);
      if (addr == 9) addr = 10;
      if (op == 1) do_write(0, ch, addr, 8'($urandom));
      else         do_read(0, ch, addr);
    end
    for (int i = 0; i < 4; i++) dbg(0, $urandom_range(0, 255));

    // Same-edge writes to one address: lowest channel wins; concurrent read sees old data.
    old = mdl[0][16];
    wv[0][1] = 1'b1; wa[0][1] = 8'd16; wd[0][1] = 8'hAA;
    wv[0][2] = 1'b1; wa[0][2] = 8'd16; wd[0][2] = 8'h55;
    rv[0][0] = 1'b1; ra[0][0] = 8'd16;
    repeat (3) @(negedge clk);
    chk("conflict_read_ready", {28'd0, rr[0]}, 32'h1);
    chk("conflict_write_ready", {28'd0, wr[0]}, 32'h6);
    chk("conflict_read_old", {24'd0, rd[0][0]}, {24'd0, old});
    rv[0] = '0; wv[0] = '0;
    @(negedge clk);
    chk("conflict_ready_fall", {28'd0, rr[0] | wr[0]}, 32'd0);
    mdl[0][16] = 8'hAA;
    dbg(0, 16);

    // Preload on the access edge beats a channel write to the same address.
    wv[0][0] = 1'b1; wa[0][0] = 8'd17; wd[0][0] = 8'h11;
    repeat (2) @(negedge clk);
    len[0] = 1'b1; ladr[0] = 8'd17; ldat[0] = 8'h99;
    @(negedge clk);
    len[0] = 1'b0;
    chk("load_vs_write_ready", {31'd0, wr[0][0]}, 32'd1);
    wv[0] = '0;
    @(negedge clk);
    mdl[0][17] = 8'h99;
    dbg(0, 17);

    // Single-port round robin: four simultaneous reads complete on consecutive cycles, twice.
    for (int burst = 0; burst < 2; burst++) begin
      rv[1] = 4'hF;
      for (int c = 0; c < 4; c++) ra[1][c] = 8'(c);
      for (int t = 1; t <= 9; t++) begin
        @(negedge clk);
        if (t == 1) rv[1] = '0;
        exp_v = (t >= 4 && t <= 7) ? (4'b0001 << (t - 4)) : 4'b0000;
        chk("rr_ready_vector", {28'd0, rr[1]}, {28'd0, exp_v});
        if (t >= 4 && t <= 7)
          chk("rr_read_data", {24'd0, rd[1][t-4]}, {24'd0, mdl[1][t-4]});
      end
    end

    // Preload blocks the single-port grant for one cycle.
    rv[1][0] = 1'b1; ra[1][0] = 8'd5;
    repeat (3) @(negedge clk);
    len[1] = 1'b1; ladr[1] = 8'd9; ldat[1] = 8'h3C;
    @(negedge clk);
    len[1] = 1'b0;
    mdl[1][9] = 8'h3C;
    chk("load_block_delayed", {31'd0, rr[1][0]}, 32'd0);
    @(negedge clk);
    chk("load_block_ready", {31'd0, rr[1][0]}, 32'd1);
    chk("load_block_data", {24'd0, rd[1][0]}, {24'd0, mdl[1][5]});
    rv[1] = '0;
    @(negedge clk);
    chk("load_block_fall", {31'd0, rr[1][0]}, 32'd0);
    dbg(1, 9);

    // Valid dropped while waiting (LATENCY=3): request still completes with a one-cycle ready.
    rv[1][0] = 1'b1; ra[1][0] = 8'd7;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      if (t == 2) rv[1][0] = 1'b0;
      chk("drop_ready_pulse", {31'd0, rr[1][0]}, (t == 4) ? 32'd1 : 32'd0);
      if (t == 4) chk("drop_read_data", {24'd0, rd[1][0]}, {24'd0, mdl[1][7]});
    end
    do_read(1, 2, 3);

    // Out-of-range: write dropped, read returns 0, no aliasing into low addresses.
    do_write(1, 1, 20, 8'h07);
    do_read(1, 1, 20);
    dbg(1, 20);
    dbg(1, 4);
    do_read(1, 3, 15);

    // Reset mid-operation: responding channel and pending write are both abandoned.
    rv[0][3] = 1'b1; ra[0][3] = 8'd2;
    repeat (3) @(negedge clk);
    chk("pre_reset_ready", {31'd0, rr[0][3]}, 32'd1);
    wv[0][0] = 1'b1; wa[0][0] = 8'd9; wd[0][0] = 8'h33;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("reset_async_read_ready", {28'd0, rr[0]}, 32'd0);
    chk("reset_async_write_ready", {28'd0, wr[0]}, 32'd0);
    chk("reset_async_read_data", rd[0], 32'd0);
    rv[0] = '0; wv[0] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    dbg(0, 9);
    do_read(0, 0, 9);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
